// File: rtl/pdua_control_unit.sv
// ============================================================================
// pdua_control_unit
// ----------------------------------------------------------------------------
// Micro-sequenced Moore control unit for the PDUA 8-bit datapath. It fetches
// each instruction (F0..F3), decodes the 5-bit opcode in DEC, fetches a
// one-word address operand (O0..O2) for memory and jump instructions, and then
// runs the short execute sequence (X0..X2 or J0). Every datapath strobe is
// decoded from the state register alone, except in DEC where the single-cycle
// register-only instructions (NOT/SHL/SHR) execute and illegal opcodes are
// flagged.
//
// Memory handshake (valid/ready): mem_req is the valid side and is held high,
// together with wr_rdn, the bus addresses and selop, from the first cycle of
// an access until the cycle in which mem_ready is seen high. The access
// completes on that rising edge. mem_ready has no effect while mem_req is low.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset (forces INIT)
//   out_IR[4:0]       opcode currently held in the IR
//   C, N, P, Z        latched ALU flags (P is not used by any instruction)
//   mem_ready         memory completes the pending access this cycle
//   mem_req, wr_rdn   memory request and direction (1 = write)
//   enaf              flag-latch enable
//   selop[2:0]        ALU operation
//   shamt[1:0]        shift control (01 = left, 10 = right)
//   bank_wr_en        register-bank write strobe
//   BusB_addr[2:0]    register-bank read index (ALU B operand)
//   BusC_addr[2:0]    register-bank write index
//   sclr              synchronous clear of the datapath registers
//   ir_en, mar_en, mdr_en   register load strobes
//   mdr_alu_n         bus-C source: 1 = MDR, 0 = ALU
//   halted            high in the HALT state
//   illegal_op        one-cycle pulse in DEC for an unknown opcode
//   dbg_state[4:0]    current FSM state, for checkers and waveforms
// ============================================================================
module pdua_control_unit #(
    parameter logic [2:0] PC_ADDR  = 3'd0,
    parameter logic [2:0] ACC_ADDR = 3'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] out_IR,
    input  logic       C,
    input  logic       N,
    input  logic       P,
    input  logic       Z,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       wr_rdn,
    output logic       enaf,
    output logic [2:0] selop,
    output logic [1:0] shamt,
    output logic       bank_wr_en,
    output logic [2:0] BusB_addr,
    output logic [2:0] BusC_addr,
    output logic       sclr,
    output logic       ir_en,
    output logic       mar_en,
    output logic       mdr_en,
    output logic       mdr_alu_n,
    output logic       halted,
    output logic       illegal_op,
    output logic [4:0] dbg_state
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [4:0] S_INIT   = 5'd0;
    localparam logic [4:0] S_F0     = 5'd1;   // MAR <- PC
    localparam logic [4:0] S_F1     = 5'd2;   // MDR <- M[MAR]
    localparam logic [4:0] S_F2     = 5'd3;   // IR  <- MDR
    localparam logic [4:0] S_F3     = 5'd4;   // PC  <- PC + 1
    localparam logic [4:0] S_DEC    = 5'd5;
    localparam logic [4:0] S_O0     = 5'd6;   // operand fetch, same as F0
    localparam logic [4:0] S_O1     = 5'd7;   // same as F1
    localparam logic [4:0] S_O2     = 5'd8;   // same as F3
    localparam logic [4:0] S_X0     = 5'd9;   // MAR <- MDR (operand address)
    localparam logic [4:0] S_X1R    = 5'd10;  // MDR <- M[MAR]
    localparam logic [4:0] S_X1W    = 5'd11;  // M[MAR] <- ACC
    localparam logic [4:0] S_X2_LDA = 5'd12;  // ACC <- MDR
    localparam logic [4:0] S_X2_ADD = 5'd13;  // ACC <- ACC + MDR
    localparam logic [4:0] S_X2_AND = 5'd14;  // ACC <- ACC & MDR
    localparam logic [4:0] S_J0     = 5'd15;  // PC  <- MDR
    localparam logic [4:0] S_HALT   = 5'd16;

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_LDA  = 5'b00001;
    localparam logic [4:0] OP_STA  = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_NOT  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_JMP  = 5'b01000;
    localparam logic [4:0] OP_JZ   = 5'b01001;
    localparam logic [4:0] OP_JN   = 5'b01010;
    localparam logic [4:0] OP_JC   = 5'b01011;
    localparam logic [4:0] OP_HALT = 5'b11111;

    // ------------------------------------------------------------------
    // ALU operation codes and shift controls
    // ------------------------------------------------------------------
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_AND    = 3'b010;
    localparam logic [2:0] ALU_PASS_B = 3'b011;
    localparam logic [2:0] ALU_NOT_A  = 3'b100;
    localparam logic [2:0] ALU_INC_B  = 3'b101;
    localparam logic [2:0] ALU_SHIFT  = 3'b110;

    localparam logic [1:0] SH_LEFT  = 2'b01;
    localparam logic [1:0] SH_RIGHT = 2'b10;

    logic [4:0] state;
    logic [4:0] state_n;

    // No instruction branches on parity; the flag is part of the flag bus.
    logic unused_flag_p;
    assign unused_flag_p = P;

    assign dbg_state = state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The opcode stays in the IR for the whole
    // instruction, so later states may still branch on out_IR. Jump
    // conditions are evaluated in O2, after the operand has been consumed,
    // so a not-taken jump still leaves PC past its operand.
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        case (state)
            S_INIT: state_n = S_F0;
            S_F0:   state_n = S_F1;
            S_F1:   state_n = mem_ready ? S_F2 : S_F1;
            S_F2:   state_n = S_F3;
            S_F3:   state_n = S_DEC;
            S_DEC: begin
                case (out_IR)
                    OP_HALT: state_n = S_HALT;
                    OP_LDA, OP_STA, OP_ADD, OP_AND,
                    OP_JMP, OP_JZ, OP_JN, OP_JC: state_n = S_O0;
                    // NOP, the register-only ops and illegal opcodes
                    default: state_n = S_F0;
                endcase
            end
            S_O0: state_n = S_O1;
            S_O1: state_n = mem_ready ? S_O2 : S_O1;
            S_O2: begin
                case (out_IR)
                    OP_JMP:  state_n = S_J0;
                    OP_JZ:   state_n = Z ? S_J0 : S_F0;
                    OP_JN:   state_n = N ? S_J0 : S_F0;
                    OP_JC:   state_n = C ? S_J0 : S_F0;
                    OP_LDA, OP_STA, OP_ADD, OP_AND: state_n = S_X0;
                    default: state_n = S_F0;
                endcase
            end
            S_X0: state_n = (out_IR == OP_STA) ? S_X1W : S_X1R;
            S_X1R: begin
                if (mem_ready) begin
                    case (out_IR)
                        OP_ADD:  state_n = S_X2_ADD;
                        OP_AND:  state_n = S_X2_AND;
                        default: state_n = S_X2_LDA;
                    endcase
                end
            end
            S_X1W:    state_n = mem_ready ? S_F0 : S_X1W;
            S_X2_LDA: state_n = S_F0;
            S_X2_ADD: state_n = S_F0;
            S_X2_AND: state_n = S_F0;
            S_J0:     state_n = S_F0;
            S_HALT:   state_n = S_HALT;
            default:  state_n = S_INIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: Moore outputs from the state register; DEC also looks
    // at out_IR so the register-only instructions finish in that cycle.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req    = 1'b0;
        wr_rdn     = 1'b0;
        enaf       = 1'b0;
        selop      = 3'b000;
        shamt      = 2'b00;
        bank_wr_en = 1'b0;
        BusB_addr  = 3'd0;
        BusC_addr  = 3'd0;
        sclr       = 1'b0;
        ir_en      = 1'b0;
        mar_en     = 1'b0;
        mdr_en     = 1'b0;
        mdr_alu_n  = 1'b0;
        halted     = 1'b0;
        illegal_op = 1'b0;

        case (state)
            S_INIT: sclr = 1'b1;

            S_F0, S_O0: begin
                BusB_addr = PC_ADDR;
                selop     = ALU_PASS_B;
                mar_en    = 1'b1;
            end

            S_F1, S_O1, S_X1R: begin
                mem_req = 1'b1;
                mdr_en  = 1'b1;
            end

            S_F2: begin
                mdr_alu_n = 1'b1;
                ir_en     = 1'b1;
            end

            S_F3, S_O2: begin
                BusB_addr  = PC_ADDR;
                BusC_addr  = PC_ADDR;
                selop      = ALU_INC_B;
                bank_wr_en = 1'b1;
            end

            S_DEC: begin
                case (out_IR)
                    OP_NOT: begin
                        selop      = ALU_NOT_A;
                        BusC_addr  = ACC_ADDR;
                        bank_wr_en = 1'b1;
                        enaf       = 1'b1;
                    end
                    OP_SHL, OP_SHR: begin
                        selop      = ALU_SHIFT;
                        shamt      = (out_IR == OP_SHL) ? SH_LEFT : SH_RIGHT;
                        BusC_addr  = ACC_ADDR;
                        bank_wr_en = 1'b1;
                        enaf       = 1'b1;
                    end
                    OP_NOP, OP_LDA, OP_STA, OP_ADD, OP_AND,
                    OP_JMP, OP_JZ, OP_JN, OP_JC, OP_HALT: ;
                    default: illegal_op = 1'b1;
                endcase
            end

            S_X0: begin
                mdr_alu_n = 1'b1;
                mar_en    = 1'b1;
            end

            // The store data travels over bus C from the ALU passing ACC.
            S_X1W: begin
                BusB_addr = ACC_ADDR;
                selop     = ALU_PASS_B;
                wr_rdn    = 1'b1;
                mem_req   = 1'b1;
            end

            S_X2_LDA: begin
                mdr_alu_n  = 1'b1;
                BusC_addr  = ACC_ADDR;
                bank_wr_en = 1'b1;
            end

            // With mdr_en and ir_en both low in an ALU state, the datapath
            // steers MDR onto the ALU B input; A is always the accumulator.
            S_X2_ADD, S_X2_AND: begin
                selop      = (state == S_X2_ADD) ? ALU_ADD : ALU_AND;
                BusB_addr  = ACC_ADDR;
                BusC_addr  = ACC_ADDR;
                bank_wr_en = 1'b1;
                enaf       = 1'b1;
            end

            S_J0: begin
                mdr_alu_n  = 1'b1;
                BusC_addr  = PC_ADDR;
                bank_wr_en = 1'b1;
            end

            S_HALT: halted = 1'b1;

            default: ;
        endcase
    end

endmodule

// File: tb/tb_pdua_control_unit.sv
// ============================================================================
// tb_pdua_control_unit
// ----------------------------------------------------------------------------
// Surrounds the control unit with a behavioural PDUA datapath and memory that
// obey the strobes it drives. Results of each program are compared with an
// instruction-level interpreter that knows only the instruction semantics and
// the published cycle counts per instruction.
// ============================================================================
module tb_pdua_control_unit;

  localparam int PC_I  = 0;
  localparam int ACC_I = 1;

  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_PASS  = 3'b011;
  localparam logic [2:0] ALU_NOT   = 3'b100;
  localparam logic [2:0] ALU_INC   = 3'b101;
  localparam logic [2:0] ALU_SHIFT = 3'b110;

  localparam logic [21:0] RESET_VEC = {2'b00, 1'b0, 3'b000, 2'b00, 1'b0, 3'b000, 3'b000,
                                       1'b1, 4'b0000, 1'b0, 1'b0};

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] out_IR;
  logic       C, N, P, Z, mem_ready;
  logic       mem_req, wr_rdn, enaf, bank_wr_en, sclr, ir_en, mar_en, mdr_en;
  logic       mdr_alu_n, halted, illegal_op;
  logic [2:0] selop, BusB_addr, BusC_addr;
  logic [1:0] shamt;
  logic [4:0] dbg_state_unused;

  pdua_control_unit dut (
    .clk(clk), .rst(rst), .out_IR(out_IR), .C(C), .N(N), .P(P), .Z(Z),
    .mem_ready(mem_ready), .mem_req(mem_req), .wr_rdn(wr_rdn), .enaf(enaf),
    .selop(selop), .shamt(shamt), .bank_wr_en(bank_wr_en),
    .BusB_addr(BusB_addr), .BusC_addr(BusC_addr), .sclr(sclr),
    .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en), .mdr_alu_n(mdr_alu_n),
    .halted(halted), .illegal_op(illegal_op), .dbg_state(dbg_state_unused)
  );

  // ---------------- environment state ----------------
  logic [7:0] image [256];   // program + data loaded at each reset
  logic [7:0] mem   [256];
  logic [7:0] mm    [256];   // interpreter's memory
  logic [7:0] bank  [8];
  logic [7:0] ir_r, mar_r, mdr_r;
  logic       fz, fn, fc, fp;

  int total, bad;
  int stall_max, stall_first, stall_left, stalls, access_no;
  bit in_access, hold_writes, prev_wait;
  logic [21:0] prev_vec;
  int ill_cnt, wr_cnt, exec_cyc, init_cnt;
  logic [7:0] wr_addr, wr_data;
  bit done;

  // interpreter results
  int m_cyc, m_ill;
  logic [7:0] m_acc, m_pc;
  logic m_z, m_n, m_c;

  function automatic logic [21:0] outs();
    return {mem_req, wr_rdn, enaf, selop, shamt, bank_wr_en, BusB_addr, BusC_addr,
            sclr, ir_en, mar_en, mdr_en, mdr_alu_n, halted, illegal_op};
  endfunction

  function automatic bit two_byte(input logic [4:0] op);
    return (op >= 5'd1 && op <= 5'd4) || (op >= 5'd8 && op <= 5'd11);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1: present IR/flags, then answer the memory request.
  task automatic drive_phase();
    out_IR = ir_r[4:0];
    Z = fz; N = fn; C = fc; P = fp;
    #1;
    if (mem_req) begin
      if (!in_access) begin
        in_access = 1'b1;
        if (access_no == 0 && stall_first > 0) stall_left = stall_first;
        else stall_left = $urandom_range(0, stall_max);
        access_no++;
      end
      if (hold_writes && wr_rdn) mem_ready = 1'b0;
      else if (stall_left > 0) begin
        mem_ready = 1'b0;
        stall_left--;
        stalls++;
      end else mem_ready = 1'b1;
    end else begin
      mem_ready = 1'($urandom_range(0, 1));   // must be ignored
    end
    #3;
  endtask

  // Called at negedge: check handshake stability and apply the edge effects.
  task automatic update_phase();
    logic [21:0] v;
    logic [7:0] a, b, r, busc;
    logic [8:0] sum;
    logic cy;
    v = outs();
    if (prev_wait) check("req_hold_stable", 32'(v), 32'(prev_vec));
    prev_wait = mem_req && !mem_ready;
    prev_vec  = v;
    if (illegal_op) ill_cnt++;
    a  = bank[ACC_I];
    b  = (selop == ALU_ADD || selop == ALU_AND) ? mdr_r : bank[BusB_addr];
    cy = 1'b0;
    sum = {1'b0, a} + {1'b0, b};
    case (selop)
      ALU_PASS:  r = b;
      ALU_INC:   r = b + 8'd1;
      ALU_ADD:   begin r = sum[7:0]; cy = sum[8]; end
      ALU_AND:   r = a & b;
      ALU_NOT:   r = ~a;
      ALU_SHIFT: r = (shamt == 2'b01) ? (a << 1) : (shamt == 2'b10) ? (a >> 1) : a;
      default:   r = 8'h00;
    endcase
    busc = mdr_alu_n ? mdr_r : r;
    if (sclr) begin
      for (int i = 0; i < 8; i++) bank[i] = 8'h00;
      ir_r = 8'h00; mar_r = 8'h00; mdr_r = 8'h00;
      fz = 1'b0; fn = 1'b0; fc = 1'b0; fp = 1'b0;
      init_cnt++;
    end else begin
      if (mem_req && mem_ready) begin
        in_access = 1'b0;
        if (wr_rdn) begin
          mem[mar_r] = busc;
          wr_cnt++;
          wr_addr = mar_r;
          wr_data = busc;
        end else if (mdr_en) begin
          mdr_r = mem[mar_r];
        end
      end
      if (bank_wr_en) bank[BusC_addr] = busc;
      if (ir_en) ir_r = busc;
      if (mar_en) mar_r = busc;
      if (enaf) begin
        fz = (r == 8'h00); fn = r[7]; fc = cy; fp = ^r;
      end
    end
  endtask

  task automatic cycle();
    drive_phase();
    update_phase();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in INIT at posedge+1 with rst low.
  task automatic reset_dut(input bit check_it);
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    if (check_it) check("reset_outputs", 32'(outs()), 32'(RESET_VEC));
    mem = image;
    for (int i = 0; i < 8; i++) bank[i] = 8'h00;
    ir_r = 8'h00; mar_r = 8'h00; mdr_r = 8'h00;
    fz = 1'b0; fn = 1'b0; fc = 1'b0; fp = 1'b0;
    in_access = 1'b0; access_no = 0; stalls = 0; stall_left = 0; prev_wait = 1'b0;
    ill_cnt = 0; wr_cnt = 0; init_cnt = 0; wr_addr = 8'h00; wr_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Runs the loaded image until HALT; exec_cyc counts cycles after INIT.
  task automatic run_prog(input int budget);
    reset_dut(1'b0);
    exec_cyc = 0;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      drive_phase();
      if (halted) done = 1'b1;
      else if (!sclr) exec_cyc++;
      update_phase();
      @(posedge clk);
      #1;
    end
    check("halt_reached", 32'(done), 32'd1);
  endtask

  // ---------------- instruction-level reference ----------------
  task automatic model_run();
    logic [7:0] pc, acc, a;
    logic [8:0] sum;
    logic [4:0] op;
    logic z, n, c, take;
    bit stop;
    mm = image;
    pc = 8'h00; acc = 8'h00; z = 1'b0; n = 1'b0; c = 1'b0;
    m_cyc = 0; m_ill = 0; stop = 1'b0;
    for (int s = 0; s < 400 && !stop; s++) begin
      op = mm[pc][4:0];
      a  = mm[pc + 8'd1];
      case (op)
        5'd0:  begin pc = pc + 8'd1; m_cyc += 5; end
        5'd5:  begin acc = ~acc; c = 1'b0; z = (acc == 0); n = acc[7]; pc = pc + 8'd1; m_cyc += 5; end
        5'd6:  begin acc = acc << 1; c = 1'b0; z = (acc == 0); n = acc[7]; pc = pc + 8'd1; m_cyc += 5; end
        5'd7:  begin acc = acc >> 1; c = 1'b0; z = (acc == 0); n = acc[7]; pc = pc + 8'd1; m_cyc += 5; end
        5'd1:  begin acc = mm[a]; pc = pc + 8'd2; m_cyc += 11; end
        5'd2:  begin mm[a] = acc; pc = pc + 8'd2; m_cyc += 10; end
        5'd3:  begin
                 sum = {1'b0, acc} + {1'b0, mm[a]};
                 acc = sum[7:0]; c = sum[8]; z = (acc == 0); n = acc[7];
                 pc = pc + 8'd2; m_cyc += 11;
               end
        5'd4:  begin acc = acc & mm[a]; c = 1'b0; z = (acc == 0); n = acc[7]; pc = pc + 8'd2; m_cyc += 11; end
        5'd8, 5'd9, 5'd10, 5'd11: begin
                 take = (op == 5'd8) || (op == 5'd9 && z) || (op == 5'd10 && n) || (op == 5'd11 && c);
                 pc = take ? a : pc + 8'd2;
                 m_cyc += take ? 9 : 8;
               end
        5'd31: begin pc = pc + 8'd1; m_cyc += 5; stop = 1'b1; end
        default: begin m_ill++; pc = pc + 8'd1; m_cyc += 5; end
      endcase
    end
    m_acc = acc; m_pc = pc; m_z = z; m_n = n; m_c = c;
  endtask

  task automatic gen_prog();
    logic [4:0] ops [16];
    int at [17];
    int n, tgt;
    logic [4:0] pool [14];
    pool = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd1, 5'd3};
    for (int i = 0; i < 256; i++) image[i] = 8'($urandom_range(0, 255));
    n = $urandom_range(4, 14);
    for (int i = 0; i < n; i++)
      ops[i] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(12, 30)) : pool[$urandom_range(0, 13)];
    ops[n] = 5'd31;
    at[0] = 0;
    for (int i = 0; i <= n; i++) at[i+1] = at[i] + (two_byte(ops[i]) ? 2 : 1);
    for (int i = 0; i <= n; i++) begin
      image[at[i]] = {3'b000, ops[i]};
      if (two_byte(ops[i])) begin
        if (ops[i] >= 5'd8) begin
          tgt = i + $urandom_range(1, 2);
          if (tgt > n) tgt = n;
          image[at[i] + 1] = 8'(at[tgt]);       // forward jumps only
        end else begin
          image[at[i] + 1] = 8'($urandom_range(128, 255));
        end
      end
    end
  endtask

  task automatic clear_image();
    for (int i = 0; i < 256; i++) image[i] = 8'h00;
  endtask

  // ---------------- DEC decode table ----------------
  typedef struct {
    logic [4:0] op;
    logic [2:0] sel;
    logic [1:0] sh;
    logic       bw;
    logic [2:0] bc;
    logic       ef;
    logic       ill;
  } dec_vec_t;

  dec_vec_t tbl [9];

  // ---------------- main test ----------------
  initial begin
    logic [21:0] exp_v;
    int diff;
    bit saw_write;
    total = 0; bad = 0;
    stall_max = 0; stall_first = 0; hold_writes = 1'b0;
    rst = 1'b0; out_IR = 5'd0; C = 1'b0; N = 1'b0; P = 1'b0; Z = 1'b0; mem_ready = 1'b0;

    tbl[0] = '{5'd0,  3'b000, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0};  // NOP
    tbl[1] = '{5'd5,  3'b100, 2'b00, 1'b1, 3'd1, 1'b1, 1'b0};  // NOT
    tbl[2] = '{5'd6,  3'b110, 2'b01, 1'b1, 3'd1, 1'b1, 1'b0};  // SHL
    tbl[3] = '{5'd7,  3'b110, 2'b10, 1'b1, 3'd1, 1'b1, 1'b0};  // SHR
    tbl[4] = '{5'd1,  3'b000, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0};  // LDA: operand first
    tbl[5] = '{5'd31, 3'b000, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0};  // HALT
    tbl[6] = '{5'd12, 3'b000, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1};  // illegal
    tbl[7] = '{5'd16, 3'b000, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1};  // illegal
    tbl[8] = '{5'd30, 3'b000, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1};  // illegal

    #1;
    clear_image();
    reset_dut(1'b1);

    // Outputs in the DEC cycle (INIT + four fetch cycles precede it).
    foreach (tbl[k]) begin
      clear_image();
      image[0] = {3'b000, tbl[k].op};
      image[1] = 8'h1F;
      reset_dut(1'b0);
      repeat (5) cycle();
      drive_phase();
      exp_v = {2'b00, tbl[k].ef, tbl[k].sel, tbl[k].sh, tbl[k].bw, 3'b000, tbl[k].bc,
               1'b0, 4'b0000, 1'b0, tbl[k].ill};
      check($sformatf("dec_op%0d", tbl[k].op), 32'(outs()), 32'(exp_v));
      update_phase();
      @(posedge clk);
      #1;
    end

    // NOP, HALT: one INIT cycle, then 5 + 5 cycles before halted.
    clear_image();
    image[0] = 8'h00; image[1] = 8'h1F;
    run_prog(100);
    check("nop_halt_init_cycles", 32'(init_cnt), 32'd1);
    check("nop_halt_cycles", 32'(exec_cyc), 32'd10);
    check("nop_halt_pc", 32'(bank[PC_I]), 32'd2);

    // Same program with the first fetch stalled three cycles.
    stall_first = 3;
    run_prog(100);
    check("stall_fetch_cycles", 32'(exec_cyc), 32'd13);
    stall_first = 0;

    // LDA 0x10 ; STA 0x20 ; HALT
    clear_image();
    image[0] = 8'h01; image[1] = 8'h10; image[2] = 8'h02; image[3] = 8'h20; image[4] = 8'h1F;
    image[8'h10] = 8'h5A;
    run_prog(200);
    check("sta_write_count", 32'(wr_cnt), 32'd1);
    check("sta_write_addr", 32'(wr_addr), 32'h20);
    check("sta_write_data", 32'(wr_data), 32'h5A);
    check("sta_mem", 32'(mem[8'h20]), 32'h5A);
    check("lda_sta_cycles", 32'(exec_cyc), 32'd26);

    // LDA 0x2F (=1) ; ADD 0x30 (=FF) ; JZ 0x40 ; 0x40: HALT
    clear_image();
    image[0] = 8'h01; image[1] = 8'h2F; image[2] = 8'h03; image[3] = 8'h30;
    image[4] = 8'h09; image[5] = 8'h40; image[6] = 8'h00; image[8'h40] = 8'h1F;
    image[8'h2F] = 8'h01; image[8'h30] = 8'hFF;
    run_prog(200);
    check("add_flag_z", 32'(fz), 32'd1);
    check("add_flag_c", 32'(fc), 32'd1);
    check("add_acc", 32'(bank[ACC_I]), 32'd0);
    check("jz_taken_pc", 32'(bank[PC_I]), 32'h41);
    check("jz_taken_cycles", 32'(exec_cyc), 32'd36);

    // LDA 0x10 (=5A) ; JN 0x40 (N=0) ; HALT
    clear_image();
    image[0] = 8'h01; image[1] = 8'h10; image[2] = 8'h0A; image[3] = 8'h40;
    image[4] = 8'h1F; image[8'h40] = 8'h1F; image[8'h10] = 8'h5A;
    run_prog(200);
    check("jn_not_taken_pc", 32'(bank[PC_I]), 32'd5);
    check("jn_not_taken_cycles", 32'(exec_cyc), 32'd24);

    // Illegal opcode 01100 then HALT.
    clear_image();
    image[0] = 8'h0C; image[1] = 8'h1F;
    run_prog(100);
    check("illegal_pulses", 32'(ill_cnt), 32'd1);
    check("illegal_pc", 32'(bank[PC_I]), 32'd2);
    check("illegal_cycles", 32'(exec_cyc), 32'd10);

    // Random programs against the instruction-level reference.
    for (int t = 0; t < 30; t++) begin
      gen_prog();
      stall_max = $urandom_range(0, 2);
      model_run();
      run_prog(2000);
      check($sformatf("rnd%0d_cycles", t), 32'(exec_cyc), 32'(m_cyc + stalls));
      check($sformatf("rnd%0d_acc", t), 32'(bank[ACC_I]), 32'(m_acc));
      check($sformatf("rnd%0d_pc", t), 32'(bank[PC_I]), 32'(m_pc));
      check($sformatf("rnd%0d_flags", t), 32'({fz, fn, fc}), 32'({m_z, m_n, m_c}));
      check($sformatf("rnd%0d_illegal", t), 32'(ill_cnt), 32'(m_ill));
      diff = 0;
      for (int i = 128; i < 256; i++) if (mem[i] !== mm[i]) diff++;
      check($sformatf("rnd%0d_data_mem", t), 32'(diff), 32'd0);
    end
    stall_max = 0;

    // Reset while STA is waiting in its write access.
    clear_image();
    image[0] = 8'h01; image[1] = 8'h10; image[2] = 8'h02; image[3] = 8'h20; image[4] = 8'h1F;
    image[8'h10] = 8'h5A;
    hold_writes = 1'b1;
    reset_dut(1'b0);
    saw_write = 1'b0;
    for (int i = 0; i < 60 && !saw_write; i++) begin
      drive_phase();
      if (mem_req && wr_rdn) saw_write = 1'b1;
      else begin
        update_phase();
        @(posedge clk);
        #1;
      end
    end
    check("sta_write_req_seen", 32'(saw_write), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_drops_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_access_outs", 32'(outs()), 32'(RESET_VEC));
    check("rst_no_write", 32'(wr_cnt), 32'd0);
    check("rst_mem_untouched", 32'(mem[8'h20]), 32'h00);
    hold_writes = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pdua_control_unit.md
# pdua_control_unit

Micro-sequenced control unit for the PDUA 8-bit datapath (ALU, register bank, IR/MAR/MDR). A Moore FSM fetches each instruction, decodes the 5-bit opcode from the IR, fetches a one-word address operand where required, and drives every datapath control strobe. It also handshakes with external memory and evaluates the ALU flags for conditional jumps. It sits beside the datapath at top level and replaces the hand-driven control vectors used in datapath benches.

## Interface
- `PC_ADDR`, default 3'd0: register-bank index of the program counter.
- `ACC_ADDR`, default 3'd1: register-bank index of the accumulator; this register is also the ALU A operand.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `out_IR`  input  5  opcode from the IR.
- `C`, `N`, `P`, `Z`  input  1 each  latched ALU flags.
- `mem_ready`  input  1  memory completes the current access in this cycle.
- `mem_req`  output  1  memory access request; held high until `mem_ready`.
- `wr_rdn`  output  1  1 = write, 0 = read.
- `enaf`  output  1  flag-latch enable.
- `selop`  output  3  ALU operation.
- `shamt`  output  2  shift amount/direction.
- `bank_wr_en`  output  1  register-bank write strobe.
- `BusB_addr`, `BusC_addr`  output  3 each  bank read and write indices.
- `sclr`  output  1  synchronous clear of the datapath registers.
- `ir_en`, `mar_en`, `mdr_en`  output  1 each  register load strobes.
- `mdr_alu_n`  output  1  bus-C source: 1 = MDR, 0 = ALU.
- `halted`  output  1  high in the HALT state.
- `illegal_op`  output  1  one-cycle pulse in DECODE when the opcode is unknown.

## Operation
- **Datapath contract:**
  - Bus C = `mdr_alu_n` ? MDR : ALU.
  - MAR, IR and the bank load from bus C.
  - MDR loads from memory when `mdr_en` is high and `wr_rdn` = 0.
  - A memory write stores the bus-C value.
- **ALU codes driven by this block:** 011 PASS_B, 101 INC_B, 001 ADD (A+B), 010 AND, 100 NOT_A, 110 SHIFT_A.
- **Default:** every strobe is 0 in every state unless listed below.
- **Fetch and decode states:**
  - INIT: `sclr`=1, then go to F0.
  - F0: BusB=PC, PASS_B, `mar_en`.
  - F1: `mem_req`, `wr_rdn`=0, `mdr_en`; stay in F1 until `mem_ready`.
  - F2: `mdr_alu_n`=1, `ir_en`.
  - F3: BusB=BusC=PC, INC_B, `bank_wr_en`.
  - DEC: branch on `out_IR`.
- **Operand fetch (O0–O2):** same actions as F0, F1, F3; MDR then holds the address.
- **Opcodes without an operand:**
  - 00000 NOP: return to F0.
  - 00101 NOT: ACC ← NOT_A, with `enaf`.
  - 00110 SHL: SHIFT_A with `shamt`=01, ACC written, with `enaf`.
  - 00111 SHR: same as SHL with `shamt`=10.
  - 11111 HALT: enter HALT and stay there until `rst`.
  - Any other opcode: pulse `illegal_op`, then return to F0 (treated as NOP).
- **Opcodes with an operand (operand fetch first):**
  - 00001 LDA: X0 (`mdr_alu_n`=1, `mar_en`) → X1 (memory read, wait for `mem_ready`) → X2 (`mdr_alu_n`=1, BusC=ACC, `bank_wr_en`).
  - 00010 STA: X0 → X1 with BusB=ACC, PASS_B, `wr_rdn`=1, `mem_req`; wait for `mem_ready`.
  - 00011 ADD and 00100 AND: X0 → X1 (read) → X2 (X2a: MDR→TMP is not allowed). Instead X2 drives `mdr_alu_n`=0, BusB=ACC_ADDR with the ALU B operand taken from MDR (B-select of MDR is datapath-internal when `mdr_en`=0 and `ir_en`=0 in ALU states), writes ACC, and asserts `enaf`.
  - 01000 JMP: J0 writes PC ← MDR (`mdr_alu_n`=1, BusC=PC, `bank_wr_en`).
  - 01001 JZ, 01010 JN, 01011 JC: execute J0 if Z, N or C respectively is 1; otherwise return directly to F0. The operand is always consumed, so PC always advances past it.
- Flags are sampled in the DEC/O2 cycle; they are never sampled mid-instruction from a flag write issued in the same instruction.

## Timing
- **Reset:** async entry to INIT. During reset all outputs are 0 except `sclr`=1. The first F0 occurs on the first edge after `rst` is deasserted.
- **Latency, zero-wait memory** (each memory state lasts ≥1 cycle; every extra cycle with `mem_ready` low adds one cycle):
  - Fetch: 4 cycles.
  - NOP, NOT, SHL, SHR: 5 cycles (including DEC).
  - Jump not taken: 8 cycles; taken: 9 cycles.
  - LDA, ADD, AND: 11 cycles. STA: 10 cycles.
- **Memory handshake:**
  - `mem_req`, `wr_rdn`, bus addresses and `selop` stay stable from request until the cycle `mem_ready` is seen.
  - `mem_ready` is ignored when `mem_req`=0.
- **Reset mid-access:** `rst` during any state returns to INIT immediately and drops `mem_req` asynchronously.
- **Outputs:** decoded purely from the state register, plus `out_IR` in DEC only. There is no input-to-output path outside DEC.
- **PC wrap-around:** PC wraps at 8 bits (255 + 1 = 0); this is handled by the datapath, and the FSM needs no special case.

## Test plan
- Reset, then program `NOP, HALT` at addresses 0–1 with zero-wait memory → INIT 1 cycle with `sclr`=1; `halted`=1 on cycle 10; PC = 2.
- `LDA 0x10` (M[0x10]=0x5A) then `STA 0x20` → memory write at 0x20 with data 0x5A, `wr_rdn`=1 for exactly one `mem_ready` cycle.
- ACC=0x01, `ADD 0x30` (M[0x30]=0xFF) then `JZ 0x40` → Z=1, C=1 after ADD; PC = 0x40 after the jump.
- `JN 0x40` with N=0 → jump not taken; PC = 4 (operand skipped); 8 cycles.
- `mem_ready` held low for 3 cycles during F1 → FSM holds F1 with stable `mem_req`; fetch takes 7 cycles.
- Opcode 01100 → `illegal_op` pulses one cycle; the next fetch starts from PC+1. Assert `rst` while in X1 of STA → `mem_req` drops, INIT, and memory is not written.
